hb_decim_stage: RTL
===================

// Module: hb_decim_stage
// PURPOSE
//  Fixed-ratio-2 halfband decimator sitting directly downstream of the CIC decimator in the DDC chain.
//  Consumes the CIC output samples (signal_out qualified by its strobe_out) and emits one filtered sample per two inputs.
//  The 23-tap symmetric halfband uses a single shared multiplier, time-multiplexed by a small MAC FSM.
// PARAMETERS
//  bw  16  sample width in and out, two's complement
//  CW  18  coefficient width, signed, Q1.17 (2^17 = 1.0); center tap fixed at 2^16
//  C0  -264  taps h[0]=h[22]
//  C1  656  taps h[2]=h[20]
//  C2  -1440  taps h[4]=h[18]
//  C3  2888  taps h[6]=h[16]
//  C4  -5712  taps h[8]=h[14]
//  C5  36640  taps h[10]=h[12]
//  Odd taps other than h[11] are zero. Default DC gain is 2*sum(C)+2^16 = 2^17 (unity).
// PORTS
//  clock  in  1  sole clock
//  reset  in  1  synchronous, active-high
//  enable  in  1  low = same clear as reset
//  strobe_in  in  1  data_in valid this cycle (CIC strobe_out)
//  data_in  in  bw  input sample
//  strobe_out  out  1  one-cycle pulse, data_out updated this cycle
//  data_out  out  bw  filtered, decimated sample (registered)
//  overrun  out  1  sticky; set when a trigger arrives while the FSM is busy
// BEHAVIOUR
//  - reset or ~enable (sampled on a clock edge): clears 23-entry history to 0, write ptr=0, phase=0, FSM=IDLE, acc=0.
//    Outputs cleared: strobe_out=0, data_out=0, overrun=0. Reset mid-computation aborts it; no strobe_out follows.
//  - Each strobe_in shifts data_in into history (x[n]=newest), then toggles phase. History addressing is circular, mod 23.
//  - A strobe_in arriving with phase=1 (2nd, 4th, ... input since reset) is a trigger.
//    A trigger computes y = sum_{j=0..22} h[j]*x[n-j], where x[n] is the triggering sample itself.
//  - FSM: IDLE -> PAIR(k=0..5) -> CTR -> RND -> IDLE.
//    IDLE: waits for a trigger.
//    PAIR k: pre-add x[n-2k] + x[n-22+2k] (bw+1 bits), multiply by Ck, accumulate. Stage registers are allowed.
//    CTR: accumulates x[n-11]*2^16.
//    RND: adds 2^16, arithmetic-shifts right by 17, then saturates to [-2^(bw-1), 2^(bw-1)-1].
//  - Accumulator width is bw+CW+3; it never wraps for any input and coefficient set.
//  - Latency: strobe_out pulses exactly 10 clocks after the trigger cycle. data_out is valid on the strobe_out cycle and holds until the next pulse.
//  - Throughput: the trigger-to-trigger spacing must be >= 11 clocks.
//    For a trigger while FSM != IDLE: the sample is still written and phase still toggles.
//    The trigger itself is dropped (no extra output) and overrun is set. The in-progress result is unaffected.
//  - strobe_in and strobe_out in the same cycle are legal and independent.
//  - Write pointer wraps 22->0 with no gap. Coefficients are compile-time constants.
// TESTING
//  - Impulse on trigger sample: 16384 then zeros.
//    -> successive outputs -33, 82, -180, 361, -714, 4580, 4580, -714, 361, -180, 82, -33, then 0.
//  - Impulse on non-trigger sample: 16384.
//    -> exactly one nonzero output, 8192, which is the 6th output after the impulse. All others 0.
//  - DC: constant 1000 at 1 strobe per 12 clocks.
//    -> from the 12th output on, data_out=1000 steady. The strobe_out count equals half the input count.
//  - Saturation: input pattern sign-matched to the taps at +/-32767.
//    -> data_out=32767 (and -32768 for the negated pattern), no wrap.
//  - Overrun: two triggers 6 clocks apart.
//    -> only the first produces strobe_out, overrun=1 until reset, and the next legal trigger output is correct.
//  - Reset asserted 4 clocks after a trigger.
//    -> no strobe_out, data_out=0, and a fresh impulse after release reproduces test 1 exactly.

Source files
------------

// File: rtl/hb_decim_stage_if.sv
// Sample stream bundle between the CIC output and the halfband decimator.
// The master drives input samples; the slave returns decimated samples and status.
interface hb_decim_stage_if #(
   parameter int BW = 16
);
   logic                 strobe_in;
   logic signed [BW-1:0] data_in;
   logic                 strobe_out;
   logic signed [BW-1:0] data_out;
   logic                 overrun;

   modport master (
      output strobe_in, data_in,
      input  strobe_out, data_out, overrun
   );

   modport slave (
      input  strobe_in, data_in,
      output strobe_out, data_out, overrun
   );
endinterface

// File: rtl/hb_decim_stage.sv
// 23-tap halfband decimate-by-2 with one shared multiplier.
// Symmetric tap pairs are pre-added so six MAC passes plus the centre tap cover the filter.
module hb_decim_stage #(
   parameter int BW = 16,
   parameter int CW = 18
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           enable,
   hb_decim_stage_if.slave bus
);
   localparam int ACC_W = BW + CW + 3;
   localparam logic signed [ACC_W-1:0] L_RND = ACC_W'(18'sd65536);
   localparam logic signed [ACC_W-1:0] L_MAX = ACC_W'($signed({1'b0, {(BW-1){1'b1}}}));
   localparam logic signed [ACC_W-1:0] L_MIN = ACC_W'($signed({1'b1, {(BW-1){1'b0}}}));

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PAIR = 2'd1,
      S_CTR  = 2'd2,
      S_RND  = 2'd3
   } state_t;

   state_t                  r_state;
   logic [2:0]              r_k;
   logic [4:0]              r_wptr;
   logic [4:0]              r_base;
   logic                    r_phase;
   logic signed [BW-1:0]    r_hist [0:22];
   logic signed [ACC_W-1:0] r_acc;
   logic signed [ACC_W-1:0] r_prod;
   logic                    r_prod_vld;
   logic signed [BW-1:0]    r_rnd;
   logic signed [BW-1:0]    r_data_out;
   logic                    r_strobe_out;
   logic                    r_overrun;

   logic                    w_clr;
   logic                    w_trig;
   logic [4:0]              w_ia;
   logic [4:0]              w_ib;
   logic [4:0]              w_ic;
   logic signed [BW-1:0]    w_xa;
   logic signed [BW-1:0]    w_xb;
   logic signed [BW-1:0]    w_xc;
   logic signed [BW:0]      w_pre;
   logic signed [CW-1:0]    w_coef;
   logic signed [ACC_W-1:0] w_prod;
   logic signed [ACC_W-1:0] w_ctr;
   logic signed [ACC_W-1:0] w_shr;
   logic signed [BW-1:0]    w_sat;

   // Circular history address of x[n-back], modulo 23.
   function automatic logic [4:0] f_idx(input logic [4:0] base, input logic [4:0] back);
      if (base >= back) begin
         f_idx = base - back;
      end else begin
         f_idx = base + 5'd23 - back;
      end
   endfunction

   function automatic logic signed [CW-1:0] f_coef(input logic [2:0] k);
      case (k)
         3'd0:    f_coef = CW'(-18'sd264);
         3'd1:    f_coef = CW'(18'sd656);
         3'd2:    f_coef = CW'(-18'sd1440);
         3'd3:    f_coef = CW'(18'sd2888);
         3'd4:    f_coef = CW'(-18'sd5712);
         3'd5:    f_coef = CW'(18'sd36640);
         default: f_coef = CW'(18'sd0);
      endcase
   endfunction

   assign w_clr  = reset | ~enable;
   assign w_trig = bus.strobe_in & r_phase;
   assign w_ia   = f_idx(r_base, {1'b0, r_k, 1'b0});
   assign w_ib   = f_idx(r_base, 5'd22 - {1'b0, r_k, 1'b0});
   assign w_ic   = f_idx(r_base, 5'd11);
   assign w_xa   = r_hist[w_ia];
   assign w_xb   = r_hist[w_ib];
   assign w_xc   = r_hist[w_ic];
   assign w_pre  = (BW+1)'(w_xa) + (BW+1)'(w_xb);
   assign w_coef = f_coef(r_k);
   assign w_prod = ACC_W'(w_pre) * ACC_W'(w_coef);
   assign w_ctr  = ACC_W'(w_xc) <<< 5'd16;
   assign w_shr  = (r_acc + L_RND) >>> 5'd17;

   // Clamp the rounded result into the output sample range.
   always_comb begin
      w_sat = w_shr[BW-1:0];
      if (w_shr > L_MAX) begin
         w_sat = L_MAX[BW-1:0];
      end else if (w_shr < L_MIN) begin
         w_sat = L_MIN[BW-1:0];
      end else begin
         w_sat = w_shr[BW-1:0];
      end
   end

   // History write, MAC sequencer and registered outputs.
   always_ff @(posedge clock) begin
      if (w_clr) begin
         for (int i = 0; i < 23; i++) begin
            r_hist[i] <= '0;
         end
         r_state      <= S_IDLE;
         r_k          <= 3'd0;
         r_wptr       <= 5'd0;
         r_base       <= 5'd0;
         r_phase      <= 1'b0;
         r_acc        <= '0;
         r_prod       <= '0;
         r_prod_vld   <= 1'b0;
         r_rnd        <= '0;
         r_data_out   <= '0;
         r_strobe_out <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_strobe_out <= 1'b0;
         r_prod_vld   <= 1'b0;
         if (r_prod_vld) begin
            r_acc <= r_acc + r_prod;
         end
         if (bus.strobe_in) begin
            r_hist[r_wptr] <= bus.data_in;
            r_wptr         <= (r_wptr == 5'd22) ? 5'd0 : r_wptr + 5'd1;
            r_phase        <= ~r_phase;
         end
         if (w_trig && (r_state != S_IDLE)) begin
            r_overrun <= 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               if (w_trig) begin
                  r_base  <= r_wptr;
                  r_k     <= 3'd0;
                  r_acc   <= '0;
                  r_state <= S_PAIR;
               end
            end
            S_PAIR: begin
               r_prod     <= w_prod;
               r_prod_vld <= 1'b1;
               if (r_k == 3'd5) begin
                  r_state <= S_CTR;
               end else begin
                  r_k <= r_k + 3'd1;
               end
            end
            S_CTR: begin
               r_prod     <= w_ctr;
               r_prod_vld <= 1'b1;
               r_k        <= 3'd0;
               r_state    <= S_RND;
            end
            // k=0 lets the centre product land, k=1 rounds, k=2 publishes.
            S_RND: begin
               if (r_k == 3'd0) begin
                  r_k <= 3'd1;
               end else if (r_k == 3'd1) begin
                  r_rnd <= w_sat;
                  r_k   <= 3'd2;
               end else begin
                  r_data_out   <= r_rnd;
                  r_strobe_out <= 1'b1;
                  r_state      <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.strobe_out = r_strobe_out;
   assign bus.data_out   = r_data_out;
   assign bus.overrun    = r_overrun;
endmodule
